// File: rtl/ssm_modexp.sv
`default_nettype none
// ============================================================================
// Module : ssm_modexp
// Left-to-right square-and-multiply sequencer driving an external ssm multiplier.
// Rev    : 1.0  initial release
// ============================================================================
module ssm_modexp #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] base_in,
  input  logic [LEN-1:0] exp_in,
  input  logic [LEN-1:0] mod_in,
  output logic           ready,
  output logic           err,
  output logic [LEN-1:0] r_out,
  output logic           mul_start,
  output logic [LEN-1:0] mul_a,
  output logic [LEN-1:0] mul_b,
  output logic [LEN-1:0] mul_n,
  input  logic           mul_ready,
  input  logic [LEN-1:0] mul_p
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_check   = 3'd1;
  localparam logic [2:0] c_bit     = 3'd2;
  localparam logic [2:0] c_prewait = 3'd3;
  localparam logic [2:0] c_issue   = 3'd4;
  localparam logic [2:0] c_wlo     = 3'd5;
  localparam logic [2:0] c_whi     = 3'd6;
  localparam logic [2:0] c_finish  = 3'd7;

  logic [2:0]       r_state;
  logic [LEN-1:0]   r_base;
  logic [LEN-1:0]   r_exp;
  logic [LEN-1:0]   r_mod;
  logic [LEN-1:0]   r_acc;
  logic [IDX_W-1:0] r_idx;
  logic             r_seen;
  logic             r_pend_mul;
  logic             r_ready;
  logic             r_err;
  logic [LEN-1:0]   r_res;
  logic [LEN-1:0]   r_a;
  logic [LEN-1:0]   r_b;
  logic [LEN-1:0]   r_n;

  logic w_bad_op;
  logic w_exp_bit;
  logic w_last;

  assign w_bad_op  = (r_mod < LEN'(2)) || (r_base >= r_mod);
  assign w_exp_bit = r_exp[r_idx];
  assign w_last    = (r_idx == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_idle;
      r_base     <= '0;
      r_exp      <= '0;
      r_mod      <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_seen     <= 1'b0;
      r_pend_mul <= 1'b0;
      r_ready    <= 1'b1;
      r_err      <= 1'b0;
      r_res      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_n        <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_base  <= base_in;
            r_exp   <= exp_in;
            r_mod   <= mod_in;
            r_ready <= 1'b0;
            r_state <= c_check;
          end
        end
        c_check: begin
          if (w_bad_op) begin
            r_err   <= 1'b1;
            r_res   <= '0;
            r_ready <= 1'b1;
            r_state <= c_idle;
          end else begin
            r_idx   <= IDX_W'(LEN - 1);
            r_seen  <= 1'b0;
            r_acc   <= LEN'(1);
            r_state <= c_bit;
          end
        end
        c_bit: begin
          if (!r_seen) begin
            // Leading zeros cost one cycle each; the first set bit just loads the base.
            if (w_exp_bit) begin
              r_acc  <= r_base;
              r_seen <= 1'b1;
            end
            if (w_last) begin
              r_state <= c_finish;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= c_bit;
            end
          end else begin
            r_a        <= r_acc;
            r_b        <= r_acc;
            r_n        <= r_mod;
            r_pend_mul <= w_exp_bit;
            r_state    <= mul_ready ? c_issue : c_prewait;
          end
        end
        c_prewait: begin
          if (mul_ready) r_state <= c_issue;
        end
        c_issue: begin
          r_state <= c_wlo;
        end
        c_wlo: begin
          if (!mul_ready) r_state <= c_whi;
        end
        c_whi: begin
          if (mul_ready) begin
            r_acc <= mul_p;
            if (r_pend_mul) begin
              r_pend_mul <= 1'b0;
              r_a        <= mul_p;
              r_b        <= r_base;
              r_state    <= c_issue;
            end else if (w_last) begin
              r_state <= c_finish;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= c_bit;
            end
          end
        end
        c_finish: begin
          r_res   <= r_acc;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign err       = r_err;
  assign r_out     = r_res;
  assign mul_start = (r_state == c_issue);
  assign mul_a     = r_a;
  assign mul_b     = r_b;
  assign mul_n     = r_n;

endmodule
`default_nettype wire

// File: tb/tb_ssm_modexp.sv
`default_nettype none
// Bench for ssm_modexp: behavioural random-latency multiplier plus a result scoreboard.
module tb_ssm_modexp;
  localparam int LEN = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [LEN-1:0] base_in = '0;
  logic [LEN-1:0] exp_in = '0;
  logic [LEN-1:0] mod_in = '0;
  logic           ready, err, mul_start, mul_ready;
  logic [LEN-1:0] r_out, mul_a, mul_b, mul_n, mul_p;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ssm_modexp #(.LEN(LEN)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_in(base_in), .exp_in(exp_in), .mod_in(mod_in),
    .ready(ready), .err(err), .r_out(r_out),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
    .mul_ready(mul_ready), .mul_p(mul_p)
  );

  // Behavioural multiplier; mul_ready can additionally be forced low until cycle hold_until.
  logic           m_ready;
  int             m_cnt;
  logic [LEN-1:0] m_a, m_b, m_n, m_p;
  int             lat_min = 1;
  int             lat_max = 3;
  int             cyc = 0;
  int             hold_until = 0;

  assign mul_ready = m_ready && (cyc >= hold_until);
  assign mul_p     = m_p;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ready <= 1'b1; m_cnt <= 0;
      m_a <= '0; m_b <= '0; m_n <= '0; m_p <= '0;
    end else if (m_ready) begin
      if (mul_start && mul_ready) begin
        m_ready <= 1'b0;
        m_a <= mul_a; m_b <= mul_b; m_n <= mul_n;
        m_cnt <= int'($urandom_range(lat_max, lat_min));
      end
    end else if (m_cnt <= 1) begin
      m_ready <= 1'b1;
      m_p <= LEN'((64'(m_a) * 64'(m_b)) % 64'(m_n));
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  int             pulses = 0;
  int             early_issue = 0;
  int             unstable = 0;
  logic [LEN-1:0] seq_a[$];
  logic [LEN-1:0] seq_b[$];

  always @(negedge clk) begin
    if (mul_start) begin
      pulses++;
      if (!mul_ready) early_issue++;
      seq_a.push_back(mul_a);
      seq_b.push_back(mul_b);
    end
    if (!m_ready && (mul_a !== m_a || mul_b !== m_b || mul_n !== m_n)) unstable++;
  end

  logic [LEN-1:0] exp_r[$];
  logic           exp_e[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [LEN-1:0] ref_modexp(input logic [LEN-1:0] b, input logic [LEN-1:0] e,
                                               input logic [LEN-1:0] m);
    longint unsigned acc, sq, ee;
    acc = 1; sq = 64'(b); ee = 64'(e);
    while (ee != 0) begin
      if (ee[0]) acc = (acc * sq) % 64'(m);
      sq = (sq * sq) % 64'(m);
      ee = ee >> 1;
    end
    return LEN'(acc % 64'(m));
  endfunction

  function automatic int n_calls(input logic [LEN-1:0] e);
    int bl;
    if (e == 0) return 0;
    bl = 0;
    for (int k = 0; k < LEN; k++) if (e[k]) bl = k + 1;
    return (bl - 1) + ($countones(e) - 1);
  endfunction

  // Called at a negedge; start is seen on the following posedge.
  task automatic launch(input logic [LEN-1:0] b, input logic [LEN-1:0] e, input logic [LEN-1:0] m);
    start = 1'b1; base_in = b; exp_in = e; mod_in = m;
    if (m < 2 || b >= m) begin
      exp_r.push_back('0); exp_e.push_back(1'b1);
    end else begin
      exp_r.push_back(ref_modexp(b, e, m)); exp_e.push_back(1'b0);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int low);
    logic [LEN-1:0] er;
    logic           ee;
    low = 0;
    while (!ready && low < 5000) begin
      low++;
      @(negedge clk);
    end
    check({tag, "_ready"}, 64'(ready), 64'd1);
    er = exp_r.pop_front();
    ee = exp_e.pop_front();
    check({tag, "_r_out"}, 64'(r_out), 64'(er));
    check({tag, "_err"}, 64'(err), 64'(ee));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int             low, p0, s0, u0, n, w, msb;
    logic [LEN-1:0] rb, re, rm, mask;
    logic [LEN-1:0] sq_a[5];
    logic [LEN-1:0] sq_b[5];
    sq_a = '{16'd4, 16'd16, 16'd64, 16'd120, 16'd484};
    sq_b = '{16'd4, 16'd4,  16'd64, 16'd120, 16'd4};

    #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    check("rst_r_out", 64'(r_out), 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_mul_ops", {16'd0, mul_a, mul_b, mul_n}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // 4^13 mod 497 with operand sequence sq, mul, sq, sq, mul
    p0 = pulses; s0 = seq_a.size(); u0 = unstable;
    launch(16'd4, 16'd13, 16'd497);
    wait_done("pow4_13", low);
    check("pow4_13_const", 64'(r_out), 64'd445);
    check("pow4_13_calls", 64'(pulses - p0), 64'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("pow4_13_a%0d", k), 64'(seq_a[s0 + k]), 64'(sq_a[k]));
      check($sformatf("pow4_13_b%0d", k), 64'(seq_b[s0 + k]), 64'(sq_b[k]));
    end
    check("pow4_13_stable", 64'(unstable - u0), 64'd0);

    p0 = pulses;
    launch(16'd2, 16'd10, 16'd1000);
    wait_done("pow2_10", low);
    check("pow2_10_const", 64'(r_out), 64'd24);
    check("pow2_10_calls", 64'(pulses - p0), 64'd4);

    p0 = pulses;
    launch(16'd3, 16'd0, 16'd7);
    wait_done("exp0", low);
    check("exp0_calls", 64'(pulses - p0), 64'd0);
    check("exp0_latency", 64'(low), 64'(LEN + 2));

    p0 = pulses;
    launch(16'd0, 16'd3, 16'd1);
    wait_done("mod1", low);
    check("mod1_latency", 64'(low), 64'd1);
    launch(16'd0, 16'd3, 16'd0);
    wait_done("mod0", low);
    check("mod0_latency", 64'(low), 64'd1);
    launch(16'd7, 16'd3, 16'd7);
    wait_done("base_eq_mod", low);
    check("base_eq_mod_latency", 64'(low), 64'd1);
    check("precond_calls", 64'(pulses - p0), 64'd0);

    // start while busy is ignored; outputs hold the previous (error) result meanwhile
    launch(16'd4, 16'd13, 16'd497);
    repeat (6) @(negedge clk);
    start = 1'b1; base_in = 16'd9; exp_in = 16'd5; mod_in = 16'd11;
    @(negedge clk);
    start = 1'b0;
    check("busy_hold_r_out", 64'(r_out), 64'd0);
    check("busy_hold_err", 64'(err), 64'd1);
    wait_done("busy_ignore", low);
    launch(16'd2, 16'd10, 16'd1000);
    wait_done("back_to_back", low);

    // async reset while waiting for a multiplier result
    lat_min = 20; lat_max = 20;
    launch(16'd3, 16'hFFFF, 16'd65521);
    n = 0;
    while (mul_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("mid_whi_reached", 64'(mul_ready), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ready", 64'(ready), 64'd1);
    check("async_rst_r_out", 64'(r_out), 64'd0);
    check("async_rst_mul_start", 64'(mul_start), 64'd0);
    void'(exp_r.pop_back());
    void'(exp_e.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    launch(16'd5, 16'd117, 16'd391);
    wait_done("after_rst", low);

    // random operands, 1..40 cycle multiplier, mul_ready held low around the first issue
    lat_min = 1; lat_max = 40;
    u0 = unstable;
    for (int t = 0; t < 200; t++) begin
      rm = LEN'($urandom_range(65535, 2));
      rb = LEN'($urandom_range(32'(rm) - 1, 0));
      w = int'($urandom_range(LEN, 1));
      mask = LEN'((32'd1 << w) - 1);
      re = LEN'($urandom) & mask;
      msb = 0;
      for (int k = 0; k < LEN; k++) if (re[k]) msb = k;
      hold_until = cyc + (LEN - msb) + 4;
      p0 = pulses;
      launch(rb, re, rm);
      wait_done($sformatf("rand%0d", t), low);
      check($sformatf("rand%0d_calls", t), 64'(pulses - p0), 64'(n_calls(re)));
    end
    check("no_early_issue", 64'(early_issue), 64'd0);
    check("rand_stable", 64'(unstable - u0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
